beat_tick_timer: RTL
====================

# beat_tick_timer

Programmable beat-period timer that paces note playback for the paper-tape player. It counts clock cycles against a runtime-loadable period, emits a one-cycle `tick` per beat, and tracks a beat index up to a programmed last beat. It supports pause/resume, stop, and looping or one-shot end-of-tape. It sits between the control FSM (start/hold/stop) and the note sequencer, which consumes `tick` and `beat_idx`.

## Interface
- `CLK_HZ`, 100_000_000: clock frequency; reset value of the period register (1 beat/s).
- `CNT_W`, 27: width of the cycle counter and period; must satisfy CLK_HZ < 2^CNT_W.
- `BEAT_W`, 8: width of the beat index.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: pulse; begins or restarts playback from beat 0.
- `hold` in 1: level; freezes the counter while high (pause music).
- `stop` in 1: pulse; abort to IDLE.
- `loop_en` in 1: level; wrap to beat 0 after the last beat instead of finishing.
- `last_beat` in BEAT_W: index of the final beat; sampled on an accepted `start`.
- `period_load` in 1: pulse; capture `period_in` into the shadow register.
- `period_in` in CNT_W: beat period in cycles; values 0 and 1 both mean 1.
- `tick` out 1: one-cycle beat pulse.
- `half_tick` out 1: one-cycle mid-beat pulse (see Configuration).
- `beat_idx` out BEAT_W: index of the beat that most recently ticked.
- `running` out 1: high in RUN.
- `paused` out 1: high in PAUSE.
- `finished` out 1: high in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Encoding is registered; all outputs are registered.
- Command priority in any state: `stop` > `start` > `hold`.
- IDLE: count=0, beat_idx=0. `start` → RUN. `hold` is ignored.
- RUN:
  - Count increments each cycle.
  - When count == P_act−1: count←0, `tick` fires, and the beat advances.
  - `hold` high → PAUSE; count and beat_idx are frozen.
- PAUSE: `hold` low → RUN, resuming from the frozen count. No tick is lost or duplicated.
- Beat advance:
  - If beat_idx != last_beat_q: beat_idx+1.
  - Else if `loop_en`: beat_idx←0 and stay in RUN.
  - Else: → DONE and beat_idx holds last_beat_q.
- The first tick after `start` reports beat_idx=0. The counter internally tracks "first beat pending".
- DONE: count=0, `finished`=1. `start` → RUN from beat 0. `stop` → IDLE.
- `start` in RUN or PAUSE restarts immediately: count=0, beat 0 pending, last_beat re-sampled.
- Period handling:
  - `period_load` writes the shadow register in any state.
  - P_act takes the shadow value on entering RUN from IDLE or DONE, on restart, and at every beat wrap.
  - A load never truncates the current beat.
- `stop` or reset mid-beat discards the partial count with no tick.
- Counter arithmetic is unsigned, CNT_W bits. Comparison uses P_act−1 with P_act ≥ 1, so the counter never wraps through 2^CNT_W.

## Timing
- Reset values:
  - Outputs: tick=0, half_tick=0, beat_idx=0, running=0, paused=0, finished=0.
  - Internal: state=IDLE, shadow period=P_act=CLK_HZ, last_beat_q=0.
- If `start` is sampled at edge E, `running`=1 after E, and the first `tick` is high in the cycle after edge E+P_act.
- Without `hold`, consecutive ticks are exactly P_act cycles apart. P=1 gives a tick every cycle.
- `hold` asserted for N cycles delays all subsequent ticks by exactly N cycles.
- `finished` rises in the same cycle as the final `tick`. `running` falls in that same cycle.

## Configuration
- `BEAT_TICK_HALF_EN` defined:
  - `half_tick` pulses when count == (P_act>>1)−1 in RUN.
  - Only for P_act ≥ 2.
  - Carries no index.
- Not defined: `half_tick` is tied to 0. The port is always present.

## Structure
- Shared package `beat_timer_pkg`:
  - State enum `bt_state_t` (IDLE/RUN/PAUSE/DONE).
  - Localparam for the default period derived from CLK_HZ.
- One sub-module: `beat_period_counter`. It holds the counter, P_act/shadow registers, and tick/half_tick generation, with an enable (RUN) and a clear input.
- The top level holds the FSM and beat index.

## Test plan
- Reset, then period_load P=4, start, last_beat=2, loop_en=0 → ticks at cycles 4, 8, 12 after start with beat_idx 0, 1, 2. `finished`=1 with the third tick. No further ticks.
- Same setup, loop_en=1, run 6 beats → beat_idx sequence 0, 1, 2, 0, 1, 2, spacing 4, `finished` never set.
- P=10, `hold` for 7 cycles mid-beat → next tick exactly 7 cycles late, `paused`=1 throughout, no tick while paused.
- period_load P=3 during a P=8 beat → current beat completes at 8, then ticks every 3 cycles.
- `start`+`stop` asserted together in RUN → IDLE, count=0, no tick. Then `start` plus P=0 → tick every cycle.
- With `BEAT_TICK_HALF_EN`, P=8 → half_tick 4 cycles after each beat start, tick at 8. Without the macro, half_tick stays 0.

Source files
------------

// File: rtl/beat_timer_pkg.sv
// beat_timer_pkg: shared state encoding and default period for the beat tick timer
package beat_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} bt_state_t;

    localparam int unsigned BT_CLK_HZ = 100_000_000;

    // One beat per second: the default period equals the clock frequency.
    function automatic int unsigned bt_def_period(input int unsigned clk_hz);
        return clk_hz;
    endfunction

    localparam int unsigned BT_DEF_PERIOD = bt_def_period(BT_CLK_HZ);

endpackage

// File: rtl/beat_period_counter.sv
// beat_period_counter: beat cycle counter with shadowed period and tick/half_tick pulses (half_tick needs BEAT_TICK_HALF_EN)
module beat_period_counter
    import beat_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = BT_CLK_HZ,
    parameter int          CNT_W  = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic             period_load,
    input  logic [CNT_W-1:0] period_in,
    output logic             at_end,
    output logic             tick,
    output logic             half_tick
);

    localparam logic [CNT_W-1:0] P_DEF = CNT_W'(bt_def_period(CLK_HZ));

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] p_act;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] shadow_d;
    logic             half_hit;

    // A period of 0 is stored as 1 so p_act-1 never underflows.
    assign shadow_d = !period_load ? shadow : (period_in == '0) ? CNT_W'(1) : period_in;
    assign at_end   = cnt == p_act - CNT_W'(1);

`ifdef BEAT_TICK_HALF_EN
    assign half_hit = (p_act >= CNT_W'(2)) && (cnt == (p_act >> 1) - CNT_W'(1));
`else
    assign half_hit = 1'b0;
`endif

    // Count cycles within a beat; the new period only takes effect at a beat boundary or (re)start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            p_act     <= P_DEF;
            shadow    <= P_DEF;
            tick      <= 1'b0;
            half_tick <= 1'b0;
        end else begin
            shadow    <= shadow_d;
            cnt       <= clr ? '0 : !en ? cnt : at_end ? '0 : cnt + CNT_W'(1);
            p_act     <= (load || (en && at_end)) ? shadow_d : p_act;
            tick      <= en && at_end;
            half_tick <= en && half_hit;
        end
    end

endmodule

// File: rtl/beat_tick_timer.sv
// beat_tick_timer: beat-period timer FSM with beat index, pause, stop and loop (half_tick via BEAT_TICK_HALF_EN)
module beat_tick_timer
    import beat_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = BT_CLK_HZ,
    parameter int          CNT_W  = 27,
    parameter int          BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [BEAT_W-1:0] last_beat,
    input  logic              period_load,
    input  logic [CNT_W-1:0]  period_in,
    output logic              tick,
    output logic              half_tick,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              running,
    output logic              paused,
    output logic              finished
);

    bt_state_t         state_q;
    bt_state_t         state_d;
    logic [BEAT_W-1:0] beat_d;
    logic [BEAT_W-1:0] last_q;
    logic [BEAT_W-1:0] last_d;
    logic [BEAT_W-1:0] nxt_idx;
    logic              pend_q;
    logic              pend_d;
    logic              at_end;
    logic              active;
    logic              cnt_en;
    logic              cnt_clr;
    logic              wrap;

    assign active  = (state_q == RUN) || (state_q == PAUSE);
    assign cnt_clr = stop || start;
    assign cnt_en  = active && !hold && !cnt_clr;
    assign wrap    = cnt_en && at_end;
    // The first tick after start reports beat 0; later ticks advance, wrapping after last_q.
    assign nxt_idx = (pend_q || beat_idx == last_q) ? '0 : beat_idx + BEAT_W'(1);

    beat_period_counter #(
        .CLK_HZ(CLK_HZ),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (cnt_en),
        .clr        (cnt_clr),
        .load       (start && !stop),
        .period_load(period_load),
        .period_in  (period_in),
        .at_end     (at_end),
        .tick       (tick),
        .half_tick  (half_tick)
    );

    // Next state and beat bookkeeping; command priority is stop, then start, then hold.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_idx;
        last_d  = last_q;
        pend_d  = pend_q;
        if (stop) begin
            state_d = IDLE;
            beat_d  = '0;
            pend_d  = 1'b0;
        end else if (start) begin
            state_d = RUN;
            beat_d  = '0;
            pend_d  = 1'b1;
            last_d  = last_beat;
        end else if (active) begin
            state_d = hold ? PAUSE : RUN;
            if (wrap) begin
                beat_d  = nxt_idx;
                pend_d  = 1'b0;
                state_d = (nxt_idx == last_q && !loop_en) ? DONE : state_d;
            end
        end
    end

    // State, beat tracking and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_idx <= '0;
            last_q   <= '0;
            pend_q   <= 1'b0;
            running  <= 1'b0;
            paused   <= 1'b0;
            finished <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_idx <= beat_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            running  <= state_d == RUN;
            paused   <= state_d == PAUSE;
            finished <= state_d == DONE;
        end
    end

endmodule
